// File: rtl/shared_reg_if.sv
// shared_reg_if -- bundle between NUM_REQ requesters and the shared register
// arbiter.
//
// Optional feature macro: SHARED_REG_LAST_OWNER_EN (adds last_owner/wr_valid).
//
// Signals:
//   req[NUM_REQ]            request per requester, held for the whole ownership
//   wr_en[NUM_REQ]          write strobe per requester
//   wdata[NUM_REQ*WIDTH]    write data, requester i owns bits [i*WIDTH +: WIDTH]
//   gnt[NUM_REQ]            registered one-hot (or zero) grant
//   q[WIDTH]                shared register contents
//   busy                    arbiter not idle
//   timeout_err             one-cycle pulse on forced revoke
//   last_owner, wr_valid    (macro only) last writer index, post-write pulse
//
// Modports: master = requester side, slave = arbiter side.
interface shared_reg_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ-1:0]       wr_en;
    logic [NUM_REQ*WIDTH-1:0] wdata;
    logic [NUM_REQ-1:0]       gnt;
    logic [WIDTH-1:0]         q;
    logic                     busy;
    logic                     timeout_err;
`ifdef SHARED_REG_LAST_OWNER_EN
    logic [$clog2(NUM_REQ)-1:0] last_owner;
    logic                       wr_valid;
`endif

    modport master (
        output req, wr_en, wdata,
`ifdef SHARED_REG_LAST_OWNER_EN
        input  last_owner, wr_valid,
`endif
        input  gnt, q, busy, timeout_err
    );

    modport slave (
        input  req, wr_en, wdata,
`ifdef SHARED_REG_LAST_OWNER_EN
        output last_owner, wr_valid,
`endif
        output gnt, q, busy, timeout_err
    );
endinterface

// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter -- round-robin arbiter granting exclusive write ownership
// of one shared WIDTH-bit register to one of NUM_REQ requesters.
//
// Optional feature macro: SHARED_REG_LAST_OWNER_EN
//   defined   : drives bus.last_owner (index of the last writer) and
//               bus.wr_valid (one-cycle pulse after each accepted write)
//   undefined : neither signal exists; core behaviour unchanged
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    shared_reg_if.slave (req/wr_en/wdata in; gnt/q/busy/timeout_err out)
//
// Ownership: IDLE arbitrates, GRANT holds one owner, RELEASE is a mandatory
// dead cycle, so consecutive owners are always separated by two gnt-low cycles.
module shared_reg_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    shared_reg_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_HOLD);

    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_e;

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] mask_q, mask_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic               timeout_err_q, timeout_err_d;

    logic [NUM_REQ-1:0] eligible;
    logic               any_eligible;
    logic [IDX_W-1:0]   winner;
    logic [IDX_W-1:0]   owner_next;
    logic               owner_req;
    logic               wr_accept;
    logic [WIDTH-1:0]   owner_wdata;

    assign eligible    = bus.req & ~mask_q;
    assign owner_req   = bus.req[owner_q];
    assign owner_wdata = bus.wdata[int'(owner_q)*WIDTH +: WIDTH];
    assign wr_accept   = (state_q == GRANT) && owner_req && bus.wr_en[owner_q];
    // Explicit wrap: NUM_REQ need not be a power of two.
    assign owner_next  = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);

    // Round-robin search: first eligible index at or above rr_ptr, wrapping.
    always_comb begin
        logic [IDX_W:0] idx;
        any_eligible = 1'b0;
        winner       = '0;
        idx          = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
            if (idx >= (IDX_W+1)'(NUM_REQ)) idx = idx - (IDX_W+1)'(NUM_REQ);
            if (!any_eligible && eligible[idx[IDX_W-1:0]]) begin
                any_eligible = 1'b1;
                winner       = idx[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        // NOTE: every _d gets a default before the case, so no path can infer a latch.
        state_d       = state_q;
        gnt_d         = gnt_q;
        owner_d       = owner_q;
        rr_ptr_d      = rr_ptr_q;
        hold_cnt_d    = hold_cnt_q;
        q_d           = q_q;
        timeout_err_d = 1'b0;
        // A revoked requester becomes eligible again only after dropping req.
        mask_d        = mask_q & bus.req;

        case (state_q)
            IDLE: begin
                if (any_eligible) begin
                    gnt_d         = '0;
                    gnt_d[winner] = 1'b1;
                    owner_d       = winner;
                    hold_cnt_d    = '0;
                    state_d       = GRANT;
                end
            end
            GRANT: begin
                if (!owner_req) begin
                    gnt_d    = '0;
                    rr_ptr_d = owner_next;
                    state_d  = RELEASE;
                end else begin
                    if (wr_accept) q_d = owner_wdata;
                    // The hold counter tracks granted edges whether or not they
                    // write, so a continuous writer is revoked as well.
                    if (hold_cnt_q == CNT_W'(MAX_HOLD - 1)) begin
                        gnt_d           = '0;
                        timeout_err_d   = 1'b1;
                        mask_d[owner_q] = 1'b1;
                        rr_ptr_d        = owner_next;
                        state_d         = RELEASE;
                    end else begin
                        hold_cnt_d = hold_cnt_q + CNT_W'(1);
                    end
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the shared register is a single architectural flop, not a memory,
    // so it is reset with the control state; a write in flight at reset is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            gnt_q         <= '0;
            mask_q        <= '0;
            owner_q       <= '0;
            rr_ptr_q      <= '0;
            hold_cnt_q    <= '0;
            q_q           <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            mask_q        <= mask_d;
            owner_q       <= owner_d;
            rr_ptr_q      <= rr_ptr_d;
            hold_cnt_q    <= hold_cnt_d;
            q_q           <= q_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus.gnt         = gnt_q;
    assign bus.q           = q_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.timeout_err = timeout_err_q;

`ifdef SHARED_REG_LAST_OWNER_EN
    logic [IDX_W-1:0] last_owner_q, last_owner_d;
    logic             wr_valid_q, wr_valid_d;

    always_comb begin
        last_owner_d = wr_accept ? owner_q : last_owner_q;
        wr_valid_d   = wr_accept;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_owner_q <= '0;
            wr_valid_q   <= 1'b0;
        end else begin
            last_owner_q <= last_owner_d;
            wr_valid_q   <= wr_valid_d;
        end
    end

    assign bus.last_owner = last_owner_q;
    assign bus.wr_valid   = wr_valid_q;
`endif
endmodule

// File: tb/tb_shared_reg_arbiter.sv
// tb_shared_reg_arbiter -- directed plus randomized bench for
// shared_reg_arbiter. The reference model tracks ownership as "current owner
// (or none) + cooldown + granted-edge count", evaluated once per clock edge.
// Inputs change on the falling edge; outputs are compared on the falling edge.
module tb_shared_reg_arbiter;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MH = 15;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    shared_reg_if #(.NUM_REQ(N), .WIDTH(W)) bus ();

    shared_reg_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_HOLD(MH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    int         m_owner;    // -1 when nobody owns the register
    bit         m_cool;     // dead cycle pending after an ownership ends
    int         m_ptr;      // index searched first at next arbitration
    int         m_held;     // granted edges seen by the current owner
    bit [N-1:0] m_blocked;  // revoked and still requesting
    logic [W-1:0] m_q;
    bit         m_to;
    int         m_last;
    bit         m_wv;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1; m_cool = 0; m_ptr = 0; m_held = 0;
        m_blocked = '0; m_q = '0; m_to = 0; m_last = 0; m_wv = 0;
    endtask

    task automatic model_edge();
        int o;
        m_to = 0;
        m_wv = 0;
        if (m_owner >= 0) begin
            o = m_owner;
            if (!bus.req[o]) begin
                m_owner = -1; m_cool = 1; m_ptr = (o + 1) % N;
            end else begin
                if (bus.wr_en[o]) begin
                    m_q = bus.wdata[o*W +: W]; m_last = o; m_wv = 1;
                end
                m_held++;
                if (m_held == MH) begin
                    m_owner = -1; m_cool = 1; m_ptr = (o + 1) % N;
                    m_blocked[o] = 1'b1; m_to = 1;
                end
            end
        end else if (m_cool) begin
            m_cool = 0;
        end else begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (bus.req[c] && !m_blocked[c]) begin
                    m_owner = c; m_held = 0;
                    break;
                end
            end
        end
        for (int i = 0; i < N; i++) if (!bus.req[i]) m_blocked[i] = 1'b0;
    endtask

    task automatic compare_all();
        check("gnt", bus.gnt, (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
        check("q", bus.q, m_q);
        check("busy", bus.busy, (m_owner >= 0) || m_cool);
        check("timeout_err", bus.timeout_err, m_to);
`ifdef SHARED_REG_LAST_OWNER_EN
        check("last_owner", bus.last_owner, m_last);
        check("wr_valid", bus.wr_valid, m_wv);
`endif
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic set_wdata(input int i, input logic [W-1:0] v);
        bus.wdata[i*W +: W] = v;
    endtask

    // Clock until some grant appears; a missing grant is a failed comparison.
    task automatic wait_grant(input string tag, input int budget);
        int n;
        n = 0;
        while (bus.gnt == '0 && n < budget) begin
            cycle();
            n++;
        end
        check(tag, (bus.gnt != '0), 1'b1);
    endtask

    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_gnt", bus.gnt, 0);
        check("rst_q", bus.q, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_to", bus.timeout_err, 0);
        @(negedge clk);
        bus.req = '0; bus.wr_en = '0;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int order_idx;
        int zeros;
        int granted;
        int pulses;
        int regrants;
        logic [N-1:0] oh;

        rst_n = 1'b1;
        bus.req = '0; bus.wr_en = '0; bus.wdata = '0;
        model_reset();
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("init_gnt", bus.gnt, 0);
        check("init_q", bus.q, 0);
        check("init_busy", bus.busy, 0);
        check("init_to", bus.timeout_err, 0);
        rst_n = 1'b1;

        // Single owner: grant one edge after req, write, release, idle.
        bus.req = 4'b0100;
        cycle();
        check("so_gnt", bus.gnt, 4'b0100);
        bus.wr_en = 4'b0100; set_wdata(2, 8'h3C);
        cycle();
        check("so_q", bus.q, 8'h3C);
        bus.wr_en = '0; bus.req = '0;
        cycle();
        check("so_rel_gnt", bus.gnt, 0);
        check("so_rel_busy", bus.busy, 1);
        cycle();
        check("so_idle_busy", bus.busy, 0);

        // Mid-run reset with q=A5 and requester 1 granted.
        bus.req = 4'b0010;
        cycle();
        check("mr_gnt", bus.gnt, 4'b0010);
        bus.wr_en = 4'b0010; set_wdata(1, 8'hA5);
        cycle();
        check("mr_q", bus.q, 8'hA5);
        bus.wr_en = '0;
        async_reset();

        // Round robin: all request, each owner writes once then drops req briefly.
        bus.req = 4'b1111;
        zeros = 0;
        for (int k = 0; k < 5; k++) begin
            for (int n = 0; n < 8 && bus.gnt == '0; n++) begin
                cycle();
                if (bus.gnt == '0) zeros++;
            end
            check("rr_granted", (bus.gnt != '0), 1'b1);
            order_idx = -1;
            for (int i = 0; i < N; i++) if (bus.gnt[i]) order_idx = i;
            check("rr_order", order_idx, k % N);
            if (k > 0) check("rr_gap", zeros, 2);
            if (order_idx < 0) order_idx = 0;
            bus.wr_en = '0; bus.wr_en[order_idx] = 1'b1;
            set_wdata(order_idx, W'($urandom));
            cycle();
            bus.wr_en = '0; bus.req[order_idx] = 1'b0;
            cycle();
            zeros = (bus.gnt == '0) ? 1 : 0;
            bus.req[order_idx] = 1'b1;
        end
        bus.req = '0;
        repeat (3) cycle();

        // Non-owner write ignored.
        bus.req = 4'b0001;
        wait_grant("no_grant", 4);
        check("no_gnt", bus.gnt, 4'b0001);
        bus.wr_en = 4'b0001; set_wdata(0, 8'h5A);
        cycle();
        check("no_q_owner", bus.q, 8'h5A);
        bus.wr_en = 4'b0010; set_wdata(1, 8'hFF);
        cycle();
        check("no_q_nonowner", bus.q, 8'h5A);
        bus.wr_en = '0; bus.req = '0;
        repeat (3) cycle();

        // Timeout: requester 3 holds req; revoked after 15 granted edges.
        bus.req = 4'b1000;
        wait_grant("to_grant", 4);
        granted = (bus.gnt[3]) ? 1 : 0;
        pulses = 0;
        for (int n = 0; n < 30 && bus.gnt[3]; n++) begin
            cycle();
            if (bus.gnt[3]) granted++;
            if (bus.timeout_err) pulses++;
        end
        check("to_hold_len", granted, MH);
        check("to_pulse_at_drop", bus.timeout_err, 1);
        regrants = 0;
        for (int n = 0; n < 10; n++) begin
            cycle();
            if (bus.gnt != '0) regrants++;
            if (bus.timeout_err) pulses++;
        end
        check("to_no_regrant", regrants, 0);
        check("to_pulses", pulses, 1);
        bus.req = 4'b1010;
        wait_grant("to_next_grant", 4);
        check("to_next_gnt", bus.gnt, 4'b0010);
        bus.req = '0;
        repeat (3) cycle();

        // Randomized traffic against the model.
        for (int n = 0; n < 800; n++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(5) == 0) bus.req[i] = ~bus.req[i];
            bus.wr_en = N'($urandom);
            bus.wdata = (N*W)'($urandom);
            cycle();
        end
        bus.req = '0; bus.wr_en = '0;
        repeat (3) cycle();

`ifdef SHARED_REG_LAST_OWNER_EN
        async_reset();
        bus.req = 4'b0100;
        wait_grant("lo_grant2", 4);
        bus.wr_en = 4'b0100; set_wdata(2, 8'h11);
        cycle();
        check("lo_owner2", bus.last_owner, 2);
        check("lo_valid2", bus.wr_valid, 1);
        bus.wr_en = '0;
        cycle();
        check("lo_valid2_off", bus.wr_valid, 0);
        bus.req = '0;
        repeat (2) cycle();
        bus.req = 4'b0001;
        wait_grant("lo_grant0", 4);
        bus.wr_en = 4'b0001; set_wdata(0, 8'h22);
        cycle();
        check("lo_owner0", bus.last_owner, 0);
        check("lo_valid0", bus.wr_valid, 1);
        check("lo_q", bus.q, 8'h22);
        bus.wr_en = '0;
        cycle();
        check("lo_valid0_off", bus.wr_valid, 0);
        bus.req = '0;
        repeat (2) cycle();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
